// File: rtl/riscv_mc_control.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback and counts retired instructions.
// Optional feature: define RISCV_ILLEGAL_TRAP_EN to trap on illegal opcodes instead of retiring them as NOPs.
module riscv_mc_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        branch,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic        retire,
  output logic [31:0] instr_count,
  output logic        illegal
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] TRAP   = 3'd5;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [2:0]  state_q, state_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [31:0] instr_count_q;
  logic        illegal_q, illegal_d;

  logic        mem_read_c, mem_write_c, ir_write_c, pc_write_c;
  logic        reg_write_c, branch_c, retire_c;
  logic [1:0]  alu_op_c;
  logic        is_exec_op, is_nop_op, is_load, is_store, is_branch, is_alu;

  // Only the opcode field steers control; the rest of the word feeds the datapath.
  logic unused_instr;
  assign unused_instr = ^instruction[31:7];

  assign is_alu    = (opcode_q == OP_ALU) || (opcode_q == OP_ALUI);
  assign is_branch = (opcode_q == OP_BRANCH);
  assign is_load   = (opcode_q == OP_LOAD);
  assign is_store  = (opcode_q == OP_STORE);
  assign is_nop_op = (opcode_q == OP_FENCE) || (opcode_q == OP_SYSTEM);
  assign is_exec_op = is_alu || is_branch || is_load || is_store ||
                      (opcode_q == OP_LUI) || (opcode_q == OP_AUIPC) ||
                      (opcode_q == OP_JAL) || (opcode_q == OP_JALR);

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    illegal_d   = illegal_q;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    branch_c    = 1'b0;
    retire_c    = 1'b0;
    alu_op_c    = 2'b00;
    case (state_q)
      FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          opcode_d   = instruction[6:0];
          state_d    = DECODE;
        end
      end
      DECODE: begin
        if (is_exec_op) begin
          state_d = EXEC;
        end else if (is_nop_op) begin
          retire_c = 1'b1;
          state_d  = FETCH;
        end else begin
`ifdef RISCV_ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = TRAP;
`else
          retire_c = 1'b1;
          state_d  = FETCH;
`endif
        end
      end
      EXEC: begin
        if (is_alu) alu_op_c = 2'b10;
        else if (is_branch) alu_op_c = 2'b01;
        if (is_branch) begin
          branch_c = 1'b1;
          retire_c = 1'b1;
          state_d  = FETCH;
        end else if (is_load || is_store) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        // Anything other than a load reaching MEM is a store.
        if (is_load) mem_read_c = 1'b1;
        else mem_write_c = 1'b1;
        if (mem_ready) begin
          if (is_load) begin
            state_d = WB;
          end else begin
            retire_c = 1'b1;
            state_d  = FETCH;
          end
        end
      end
      WB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = FETCH;
      end
      TRAP: begin
`ifdef RISCV_ILLEGAL_TRAP_EN
        state_d = TRAP;
`else
        state_d = FETCH;
`endif
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      opcode_q      <= 7'd0;
      instr_count_q <= 32'd0;
      illegal_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      if (retire_c) instr_count_q <= instr_count_q + 32'd1;
    end
  end

  // Strobes are suppressed combinationally for the whole reset cycle.
  assign mem_read    = mem_read_c  & ~rst;
  assign mem_write   = mem_write_c & ~rst;
  assign ir_write    = ir_write_c  & ~rst;
  assign pc_write    = pc_write_c  & ~rst;
  assign reg_write   = reg_write_c & ~rst;
  assign branch      = branch_c    & ~rst;
  assign retire      = retire_c    & ~rst;
  assign alu_op      = alu_op_c;
  assign state       = state_q;
  assign instr_count = instr_count_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Directed-vector bench for riscv_mc_control; strobe vectors are {mem_read,mem_write,ir_write,pc_write,reg_write,branch,retire}.
module tb_riscv_mc_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        mem_ready;
  logic        mem_read, mem_write, ir_write, pc_write, reg_write, branch, retire, illegal;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] instr_count;

  int checkCount = 0;
  int failCount  = 0;
  logic [31:0] expCount;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_LW    = 32'h0000A103;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_ILL   = 32'hFFFFFFFF;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_FENCE = 32'h0000000F;
  localparam logic [31:0] I_SYS   = 32'h00000073;

  riscv_mc_control dut (
    .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .branch(branch), .alu_op(alu_op), .state(state),
    .retire(retire), .instr_count(instr_count), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic ready);
    instruction = instr;
    mem_ready   = ready;
    #1;
  endtask

  task automatic checkCycle(input string tag, input logic [2:0] expState,
                            input logic [6:0] expStrobes, input logic [1:0] expAlu);
    checkOutput({tag, ".state"}, {29'd0, state}, {29'd0, expState});
    checkOutput({tag, ".strobes"},
                {25'd0, mem_read, mem_write, ir_write, pc_write, reg_write, branch, retire},
                {25'd0, expStrobes});
    checkOutput({tag, ".alu_op"}, {30'd0, alu_op}, {30'd0, expAlu});
  endtask

  task automatic checkCounters(input string tag, input logic expIllegal);
    checkOutput({tag, ".count"}, instr_count, expCount);
    checkOutput({tag, ".illegal"}, {31'd0, illegal}, {31'd0, expIllegal});
  endtask

  initial begin
    rst = 1'b1;
    instruction = 32'd0;
    mem_ready = 1'b1;
    expCount = 32'd0;
    tick();
    tick();
    applyStimulus(I_ADD, 1'b1);
    checkCycle("reset", 3'd0, 7'b0000000, 2'b00);
    checkCounters("reset", 1'b0);

    // ADD: FETCH, DECODE, EXEC, WB
    rst = 1'b0;
    applyStimulus(I_ADD, 1'b1);
    checkCycle("add.F", 3'd0, 7'b1011000, 2'b00);
    tick(); applyStimulus(I_ADD, 1'b1);
    checkCycle("add.D", 3'd1, 7'b0000000, 2'b00);
    tick(); applyStimulus(I_ADD, 1'b1);
    checkCycle("add.E", 3'd2, 7'b0000000, 2'b10);
    tick(); applyStimulus(I_ADD, 1'b1);
    checkCycle("add.WB", 3'd4, 7'b0000101, 2'b00);
    expCount = 32'd1;

    // LW with three wait cycles in MEM
    tick(); applyStimulus(I_LW, 1'b1);
    checkCycle("lw.F", 3'd0, 7'b1011000, 2'b00);
    checkCounters("add.done", 1'b0);
    tick(); applyStimulus(I_LW, 1'b1);
    checkCycle("lw.D", 3'd1, 7'b0000000, 2'b00);
    tick(); applyStimulus(I_LW, 1'b0);
    checkCycle("lw.E", 3'd2, 7'b0000000, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick(); applyStimulus(I_LW, 1'b0);
      checkCycle($sformatf("lw.Mwait%0d", i), 3'd3, 7'b1000000, 2'b00);
    end
    tick(); applyStimulus(I_LW, 1'b1);
    checkCycle("lw.Mready", 3'd3, 7'b1000000, 2'b00);
    tick(); applyStimulus(I_BEQ, 1'b1);
    checkCycle("lw.WB", 3'd4, 7'b0000101, 2'b00);
    checkCounters("lw.WB", 1'b0);
    expCount = 32'd2;

    // BEQ resolves in EXEC
    tick(); applyStimulus(I_BEQ, 1'b1);
    checkCycle("beq.F", 3'd0, 7'b1011000, 2'b00);
    checkCounters("lw.done", 1'b0);
    tick(); applyStimulus(I_BEQ, 1'b1);
    checkCycle("beq.D", 3'd1, 7'b0000000, 2'b00);
    tick(); applyStimulus(I_ILL, 1'b1);
    checkCycle("beq.E", 3'd2, 7'b0000011, 2'b01);
    expCount = 32'd3;

    // Illegal opcode
    tick(); applyStimulus(I_ILL, 1'b1);
    checkCycle("ill.F", 3'd0, 7'b1011000, 2'b00);
    checkCounters("beq.done", 1'b0);
    tick(); applyStimulus(I_ILL, 1'b0);
`ifdef RISCV_ILLEGAL_TRAP_EN
    checkCycle("ill.D", 3'd1, 7'b0000000, 2'b00);
    for (int i = 0; i < 10; i++) begin
      tick(); applyStimulus(I_ILL, 1'b1);
      checkCycle($sformatf("ill.trap%0d", i), 3'd5, 7'b0000000, 2'b00);
      checkCounters($sformatf("ill.trap%0d", i), 1'b1);
    end
`else
    checkCycle("ill.D", 3'd1, 7'b0000001, 2'b00);
    expCount = 32'd4;
    tick(); applyStimulus(I_ILL, 1'b0);
    checkCycle("ill.after", 3'd0, 7'b1000000, 2'b00);
    checkCounters("ill.after", 1'b0);
`endif

    // Reset clears counters and any trap
    rst = 1'b1;
    applyStimulus(I_SW, 1'b1);
    checkCycle("rst2.during", state, 7'b0000000, 2'b00);
    tick();
    rst = 1'b0;
    expCount = 32'd0;
    applyStimulus(I_SW, 1'b1);
    checkCycle("sw.F", 3'd0, 7'b1011000, 2'b00);
    checkCounters("rst2.after", 1'b0);

    // SW completing with zero-wait memory
    tick(); applyStimulus(I_SW, 1'b1);
    checkCycle("sw.D", 3'd1, 7'b0000000, 2'b00);
    tick(); applyStimulus(I_SW, 1'b1);
    checkCycle("sw.E", 3'd2, 7'b0000000, 2'b00);
    tick(); applyStimulus(I_SW, 1'b1);
    checkCycle("sw.M", 3'd3, 7'b0100001, 2'b00);
    expCount = 32'd1;

    // Second SW aborted by reset mid-MEM
    tick(); applyStimulus(I_SW, 1'b1);
    checkCycle("sw2.F", 3'd0, 7'b1011000, 2'b00);
    checkCounters("sw.done", 1'b0);
    tick(); applyStimulus(I_SW, 1'b1);
    tick(); applyStimulus(I_SW, 1'b0);
    tick(); applyStimulus(I_SW, 1'b0);
    checkCycle("sw2.Mwait", 3'd3, 7'b0100000, 2'b00);
    rst = 1'b1;
    applyStimulus(I_SW, 1'b0);
    checkCycle("sw2.rst", 3'd3, 7'b0000000, 2'b00);
    tick();
    rst = 1'b0;
    expCount = 32'd0;
    applyStimulus(I_SW, 1'b0);
    checkCycle("sw2.aborted", 3'd0, 7'b1000000, 2'b00);
    checkCounters("sw2.aborted", 1'b0);

    // Counter wrap: preload the count register, then retire a FENCE
    dut.instr_count_q <= 32'hFFFF_FFFF;
    #1;
    expCount = 32'hFFFF_FFFF;
    checkCounters("wrap.preload", 1'b0);
    applyStimulus(I_FENCE, 1'b1);
    tick(); applyStimulus(I_SYS, 1'b1);
    checkCycle("fence.D", 3'd1, 7'b0000001, 2'b00);
    tick(); applyStimulus(I_SYS, 1'b1);
    expCount = 32'd0;
    checkCycle("sys.F", 3'd0, 7'b1011000, 2'b00);
    checkCounters("wrap.done", 1'b0);
    tick(); applyStimulus(I_SYS, 1'b0);
    checkCycle("sys.D", 3'd1, 7'b0000001, 2'b00);
    tick(); applyStimulus(I_SYS, 1'b0);
    expCount = 32'd1;
    checkCounters("sys.done", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
    $finish;
  end

endmodule
